// File: rtl/core_mem_pkg.sv
// Shared types for the core memory arbiter: FSM state encoding and the
// data-grant streak counter width.
package core_mem_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_IF_WAIT,
      ARB_DM_WAIT
   } arb_state_t;

   localparam int STREAK_W = 4;

endpackage

// File: rtl/core_mem_arbiter.sv
// Arbitrates the single-port backing memory between instruction fetch and
// the memory stage, with a bounded data-priority streak and fetch squashing.
module core_mem_arbiter
   import core_mem_pkg::*;
#(
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              flush_f,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_stall,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [STREAK_W-1:0] MAX_STREAK = STREAK_W'(MAX_DATA_STREAK);

   arb_state_t          state_reg;
   logic [STREAK_W-1:0] streak_reg;
   logic                squash_reg;
   logic                grant_dm;
   logic                grant_if;

   // Data wins a tie until it has taken MAX_DATA_STREAK grants in a row
   // while a fetch was waiting.
   always_comb begin
      grant_dm = dm_req & (~if_req | (streak_reg < MAX_STREAK));
      grant_if = if_req & ~grant_dm;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= ARB_IDLE;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         streak_reg <= '0;
         squash_reg <= 1'b0;
      end else begin
         case (state_reg)
            ARB_IDLE: begin
               if (grant_dm) begin
                  mem_req   <= 1'b1;
                  mem_we    <= dm_we;
                  mem_addr  <= dm_addr;
                  mem_wdata <= dm_wdata;
                  state_reg <= ARB_DM_WAIT;
                  if (if_req)
                     streak_reg <= (streak_reg == '1) ? streak_reg : streak_reg + 1'b1;
                  else
                     streak_reg <= '0;
               end else if (grant_if) begin
                  mem_req    <= 1'b1;
                  mem_we     <= 1'b0;
                  mem_addr   <= if_addr;
                  state_reg  <= ARB_IF_WAIT;
                  streak_reg <= '0;
               end
            end
            ARB_IF_WAIT: begin
               // A redirect during the fetch poisons its response; the bus
               // access itself still runs to completion.
               if (flush_f)
                  squash_reg <= 1'b1;
               if (mem_ack) begin
                  mem_req    <= 1'b0;
                  squash_reg <= 1'b0;
                  state_reg  <= ARB_IDLE;
               end
            end
            ARB_DM_WAIT: begin
               if (mem_ack) begin
                  mem_req   <= 1'b0;
                  state_reg <= ARB_IDLE;
               end
            end
            default: begin
               mem_req   <= 1'b0;
               state_reg <= ARB_IDLE;
            end
         endcase
      end
   end

   assign if_rdata = mem_rdata;
   assign dm_rdata = mem_rdata;

   assign dm_stall = dm_req & ~((state_reg == ARB_DM_WAIT) & mem_ack);
   assign if_stall = if_req & ~((state_reg == ARB_IF_WAIT) & mem_ack & ~squash_reg & ~flush_f);

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter: a transaction-level model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_core_mem_arbiter;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int MAX_STREAK = 4;

   localparam int O_NONE = 0;
   localparam int O_IF   = 1;
   localparam int O_DM   = 2;

   localparam int EV_RISE  = 0;
   localparam int EV_ACK   = 1;
   localparam int EV_DMREL = 2;
   localparam int EV_IFREL = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              flush_f;
   logic [DATA_W-1:0] if_rdata;
   logic              if_stall;
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_stall;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   int tests_run    = 0;
   int tests_failed = 0;

   // memory responder controls
   int   lat       = 1;
   int   age       = 0;
   logic resp_ack  = 1'b0;
   logic force_ack = 1'b0;

   // transaction model state
   int          m_owner  = O_NONE;
   logic        m_we     = 1'b0;
   logic [31:0] m_addr   = '0;
   logic [31:0] m_wdata  = '0;
   int          m_streak = 0;
   logic        m_squash = 1'b0;

   byte  grant_q[$];
   logic prev_req = 1'b0;

   core_mem_arbiter #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .MAX_DATA_STREAK(MAX_STREAK)
   ) dut (
      .clk(clk),
      .reset(reset),
      .if_req(if_req),
      .if_addr(if_addr),
      .flush_f(flush_f),
      .if_rdata(if_rdata),
      .if_stall(if_stall),
      .dm_req(dm_req),
      .dm_we(dm_we),
      .dm_addr(dm_addr),
      .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata),
      .dm_stall(dm_stall),
      .mem_req(mem_req),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_ack(mem_ack),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rd_word(input logic [31:0] a);
      if (a == 32'h0040_0000) return 32'h2008_0005;
      return a ^ 32'hA5A5_5A5A;
   endfunction

   assign mem_ack   = force_ack | (resp_ack & mem_req);
   assign mem_rdata = mem_ack ? rd_word(mem_addr) : 32'h0;

   // Memory acks lat cycles after mem_req rises.
   always @(posedge clk) begin
      #1;
      if (!mem_req) begin
         age      = 0;
         resp_ack = 1'b0;
      end else begin
         age      = age + 1;
         resp_ack = (age == lat + 1);
      end
   end

   // One access at a time; a grant is decided from the requests seen on the
   // edge that ends an idle cycle, and the access ends on the edge after ack.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_owner  = O_NONE;
         m_we     = 1'b0;
         m_addr   = '0;
         m_wdata  = '0;
         m_streak = 0;
         m_squash = 1'b0;
      end else if (m_owner == O_NONE) begin
         if (dm_req && (!if_req || m_streak < MAX_STREAK)) begin
            m_owner  = O_DM;
            m_we     = dm_we;
            m_addr   = dm_addr;
            m_wdata  = dm_wdata;
            m_streak = if_req ? ((m_streak < 15) ? m_streak + 1 : 15) : 0;
         end else if (if_req) begin
            m_owner  = O_IF;
            m_we     = 1'b0;
            m_addr   = if_addr;
            m_streak = 0;
         end
      end else begin
         if (m_owner == O_IF && flush_f) m_squash = 1'b1;
         if (mem_ack) begin
            $display("[TB] %s access addr=%h we=%0d squashed=%0d",
                     (m_owner == O_IF) ? "fetch" : "data ", m_addr, m_we, m_squash);
            m_owner  = O_NONE;
            m_squash = 1'b0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run = tests_run + 1;
      if (act !== exp) begin
         tests_failed = tests_failed + 1;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_evt(input int kind, output int n);
      bit found;
      found = 1'b0;
      n = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         n = n + 1;
         case (kind)
            EV_RISE:  found = (mem_req === 1'b1);
            EV_ACK:   found = (mem_ack === 1'b1);
            EV_DMREL: found = (dm_req && dm_stall === 1'b0);
            default:  found = (if_req && if_stall === 1'b0);
         endcase
      end
      if (!found) begin
         tests_run    = tests_run + 1;
         tests_failed = tests_failed + 1;
         $display("FAIL wait_timeout: event %0d not seen in 40 cycles", kind);
      end
   endtask

   task automatic cycle_check;
      logic exp_req, exp_if_stall, exp_dm_stall;
      if (mem_req && !prev_req) grant_q.push_back(mem_we ? "D" : "F");
      prev_req = mem_req;
      if (reset === 1'b1) begin
         exp_req      = (m_owner != O_NONE);
         exp_dm_stall = dm_req & ~(m_owner == O_DM && mem_ack);
         exp_if_stall = if_req & ~(m_owner == O_IF && mem_ack && !m_squash && !flush_f);
         chk("cyc_mem_req", 32'(mem_req), 32'(exp_req));
         chk("cyc_dm_stall", 32'(dm_stall), 32'(exp_dm_stall));
         chk("cyc_if_stall", 32'(if_stall), 32'(exp_if_stall));
         if (exp_req) begin
            chk("cyc_mem_we", 32'(mem_we), 32'(m_we));
            chk("cyc_mem_addr", mem_addr, m_addr);
            if (m_we) chk("cyc_mem_wdata", mem_wdata, m_wdata);
         end
         if (mem_ack) begin
            chk("cyc_if_rdata", if_rdata, mem_rdata);
            chk("cyc_dm_rdata", dm_rdata, mem_rdata);
         end
      end
   endtask

   initial begin
      int    n;
      int    start;
      string log_s;

      reset = 1'b0; if_req = 1'b0; if_addr = '0; flush_f = 1'b0;
      dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;

      fork
         forever begin
            @(negedge clk);
            cycle_check();
         end
      join_none

      // reset state
      lat = 3;
      repeat (3) tick();
      chk("rst_mem_req", 32'(mem_req), 32'h0);
      chk("rst_mem_we", 32'(mem_we), 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_dm_stall", 32'(dm_stall), 32'h0);
      chk("rst_if_stall", 32'(if_stall), 32'h0);
      reset = 1'b1;
      tick();

      // single fetch, ack 3 cycles after mem_req rises
      if_req = 1'b1; if_addr = 32'h0040_0000;
      @(negedge clk);
      chk("f1_req_idle", 32'(mem_req), 32'h0);
      chk("f1_stall_idle", 32'(if_stall), 32'h1);
      @(negedge clk);
      chk("f1_req_rise", 32'(mem_req), 32'h1);
      chk("f1_addr", mem_addr, 32'h0040_0000);
      chk("f1_we", 32'(mem_we), 32'h0);
      wait_evt(EV_ACK, n);
      chk("f1_ack_lat", 32'(n), 32'd3);
      chk("f1_stall_rel", 32'(if_stall), 32'h0);
      chk("f1_rdata", if_rdata, 32'h2008_0005);
      tick();
      if_req = 1'b0;
      tick();

      // simultaneous requests: data first, fetch after one idle cycle
      lat = 1;
      if_req = 1'b1; if_addr = 32'h0040_0004;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1001_0000;
      @(negedge clk);
      @(negedge clk);
      chk("both_first_addr", mem_addr, 32'h1001_0000);
      wait_evt(EV_ACK, n);
      chk("both_dm_rel", 32'(dm_stall), 32'h0);
      chk("both_if_held", 32'(if_stall), 32'h1);
      tick();
      dm_req = 1'b0;
      @(negedge clk);
      chk("both_idle_gap", 32'(mem_req), 32'h0);
      @(negedge clk);
      chk("both_f_req", 32'(mem_req), 32'h1);
      chk("both_f_addr", mem_addr, 32'h0040_0004);
      wait_evt(EV_IFREL, n);
      chk("both_f_rdata", if_rdata, 32'hA5E5_5A5E);
      tick();
      if_req = 1'b0;
      tick();

      // six back-to-back stores against a waiting fetch
      start = grant_q.size();
      if_req = 1'b1; if_addr = 32'h0040_0008;
      for (int i = 0; i < 6; i++) begin
         dm_req = 1'b1; dm_we = 1'b1;
         dm_addr  = 32'h1002_0000 + 32'(4 * i);
         dm_wdata = 32'h0000_1000 + 32'(i);
         wait_evt(EV_DMREL, n);
         tick();
      end
      dm_req = 1'b0; dm_we = 1'b0; if_req = 1'b0;
      log_s = "";
      for (int k = start; k < grant_q.size(); k++) log_s = $sformatf("%s%c", log_s, grant_q[k]);
      tests_run = tests_run + 1;
      if (log_s != "DDDDFDD") begin
         tests_failed = tests_failed + 1;
         $display("FAIL streak_order: got %s expected DDDDFDD", log_s);
      end
      tick();

      // flush during a fetch
      lat = 2;
      if_req = 1'b1; if_addr = 32'h0040_0010;
      tick();
      flush_f = 1'b1; if_addr = 32'h0040_0040;
      tick();
      flush_f = 1'b0;
      wait_evt(EV_ACK, n);
      chk("flush_stall_held", 32'(if_stall), 32'h1);
      chk("flush_old_addr", mem_addr, 32'h0040_0010);
      wait_evt(EV_IFREL, n);
      chk("flush_new_addr", mem_addr, 32'h0040_0040);
      chk("flush_new_rdata", if_rdata, 32'hA5E5_5A1A);
      tick();
      if_req = 1'b0;
      tick();

      // asynchronous reset in the middle of a data access
      lat = 5;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1001_0008;
      @(negedge clk);
      @(negedge clk);
      chk("ar_granted", 32'(mem_req), 32'h1);
      #2 reset = 1'b0;
      #1;
      chk("ar_mem_req", 32'(mem_req), 32'h0);
      chk("ar_mem_addr", mem_addr, 32'h0);
      chk("ar_dm_stall", 32'(dm_stall), 32'h1);
      tick();
      tick();
      lat = 1;
      reset = 1'b1; force_ack = 1'b1;
      @(negedge clk);
      chk("ar_stray_ack_stall", 32'(dm_stall), 32'h1);
      chk("ar_stray_ack_req", 32'(mem_req), 32'h0);
      tick();
      force_ack = 1'b0;
      wait_evt(EV_DMREL, n);
      chk("ar_retry_rdata", dm_rdata, 32'hB5A4_5A52);
      tick();
      dm_req = 1'b0;
      tick();

      // store with single-cycle ack latency
      lat = 1;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h1001_0004; dm_wdata = 32'hDEAD_BEEF;
      wait_evt(EV_RISE, n);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         chk("st_we", 32'(mem_we), 32'h1);
         chk("st_addr", mem_addr, 32'h1001_0004);
         chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
         if (mem_ack) break;
         n = n + 1;
         @(negedge clk);
      end
      chk("st_ack_delay", 32'(n), 32'd1);
      chk("st_dm_rel", 32'(dm_stall), 32'h0);
      tick();
      dm_req = 1'b0; dm_we = 1'b0;
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Shares one single-port backing memory between the fetch stage (read-only) and the memory stage (read/write) of the pipelined core.
- Grants one access at a time and holds the memory request stable until it is acknowledged.
- Drives per-requester stall signals into the hazard unit.
- Discards fetch responses squashed by a branch mispredict or jump redirect.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port
- DATA_W, 32, data width
- MAX_DATA_STREAK, 4, consecutive data grants allowed while a fetch waits (range 1..15)

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- if_req  in  1  fetch stage requests an instruction read
- if_addr  in  ADDR_W  fetch address (the pc)
- flush_f  in  1  in-flight fetch is wrong-path; discard its response
- if_rdata  out  DATA_W  instruction word, valid when if_req=1 and if_stall=0
- if_stall  out  1  fetch must hold
- dm_req  in  1  memory stage requests a load or store
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data, valid when dm_req=1 and dm_stall=0
- dm_stall  out  1  memory stage must hold
- mem_req  out  1  backing memory request
- mem_we  out  1  backing memory write enable
- mem_addr  out  ADDR_W  backing memory address
- mem_wdata  out  DATA_W  backing memory write data
- mem_ack  in  1  one-cycle pulse: access complete, mem_rdata valid
- mem_rdata  in  DATA_W  backing memory read data

Behaviour:
- State machine with states ARB_IDLE, ARB_IF_WAIT and ARB_DM_WAIT.
- Reset values: state=ARB_IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, streak=0, squash=0.
- Reset is asynchronous; asserting it mid-access abandons the access immediately and any later mem_ack is ignored (state is ARB_IDLE).
- In ARB_IDLE, arbitrate on the current if_req and dm_req:
  - both low: stay in ARB_IDLE.
  - dm_req only: grant data.
  - if_req only: grant fetch.
  - both high: grant data if streak < MAX_DATA_STREAK, otherwise grant fetch.
- Data grant:
  - capture dm_we, dm_addr and dm_wdata into the mem_* registers; mem_req=1 next cycle.
  - go to ARB_DM_WAIT.
  - streak increments (saturating) only if if_req was high in the grant cycle; otherwise streak clears to 0.
- Fetch grant:
  - capture if_addr with mem_we=0; mem_req=1 next cycle.
  - go to ARB_IF_WAIT; streak clears to 0.
- WAIT states:
  - mem_req and all mem_* outputs are held constant until mem_ack=1 is sampled.
  - On mem_ack: mem_req=0 at the next edge and the state returns to ARB_IDLE.
  - Minimum access time is 2 cycles (grant cycle + ack cycle), plus one ARB_IDLE cycle between accesses.
- mem_ack seen in ARB_IDLE is ignored. mem_ack is never presented in the same cycle mem_req rises.
- Read data paths are combinational pass-through: if_rdata=mem_rdata and dm_rdata=mem_rdata, meaningful only in the release cycle.
- dm_stall = dm_req & ~(state==ARB_DM_WAIT & mem_ack).
- if_stall = if_req & ~(state==ARB_IF_WAIT & mem_ack & ~squash & ~flush_f).
- Squash handling:
  - flush_f=1 while in ARB_IF_WAIT sets squash; squash clears on leaving ARB_IF_WAIT.
  - A squashed fetch still completes on the bus, but if_stall stays 1 and the redirected pc is fetched afresh after ARB_IDLE.
  - flush_f in ARB_IDLE or ARB_DM_WAIT has no effect.
- A requester dropping its req mid-access does not abort the access: it runs to completion and the response is dropped.
- Stores and loads complete identically; a store's mem_rdata is don't-care.
- A stall is never released without a matching mem_ack.

Decomposition:
- Shared package core_mem_pkg holds:
  - typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_IF_WAIT, ARB_DM_WAIT}.
  - localparam STREAK_W = 4.
- No sub-module: the FSM, capture registers, streak counter and squash flag are all local.
- Instantiated beside core_datapath. Its stall outputs are ORed with the hazard unit's stall_f and stall_d.

Test Plan:
- Reset, then if_req=1, if_addr=0x00400000, memory acks 3 cycles after mem_req rises:
  - mem_req rises one cycle after the request, with mem_addr=0x00400000 and mem_we=0.
  - if_stall=1 until the ack cycle; if_rdata=mem_rdata=0x20080005 in that cycle.
- if_req and dm_req (load, 0x10010000) raised together in ARB_IDLE:
  - the data access is granted first; dm_stall drops on its ack.
  - the fetch is granted next, after one ARB_IDLE cycle.
- dm_req held high for 6 back-to-back stores with if_req=1, MAX_DATA_STREAK=4:
  - grant order is D D D D F D D; streak returns to 0 after the fetch grant.
- flush_f pulsed one cycle into a fetch of 0x00400010:
  - at mem_ack, if_stall stays 1.
  - a new fetch of the updated if_addr=0x00400040 is issued afterwards and delivers normally.
- reset driven low while in ARB_DM_WAIT:
  - mem_req=0 and state=ARB_IDLE immediately, with no clock edge needed.
  - a mem_ack arriving after reset is released causes no stall release.
- Store with dm_we=1, dm_addr=0x10010004, dm_wdata=0xDEADBEEF and ack after 1 cycle:
  - mem_we=1, mem_addr and mem_wdata are stable for every mem_req=1 cycle.
  - dm_stall is released in the ack cycle.
